// File: rtl/interrupt_controller.sv
// Vectored interrupt controller: edge-detects an active-low device request,
// latches per-vector pending bits and data words, and presents the lowest
// enabled pending vector to a CPU through an IDLE/REQ/SERVICE handshake.
module interrupt_controller #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              srcIrq_n,
   input  logic [3:0]        srcIndex,
   input  logic [DATA_W-1:0] srcData,
   input  logic              maskWe,
   input  logic [15:0]       maskIn,
   input  logic              ovrClr,
   input  logic              cpuAck,
   input  logic              cpuEoi,
   output logic              cpuIrq,
   output logic [3:0]        cpuVector,
   output logic [DATA_W-1:0] cpuData,
   output logic [15:0]       pending,
   output logic              overrun
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Lowest set index of req; bit 4 flags that any bit was set.
   function automatic logic [4:0] find_winner(input logic [15:0] req);
      logic [4:0] res;
      res = 5'd0;
      for (int i = 15; i >= 0; i--) begin
         res = req[i] ? {1'b1, 4'(i)} : res;
      end
      return res;
   endfunction

   state_t            state_r, state_nxt_s;
   logic              prev_irq_r;
   logic [15:0]       mask_r;
   logic [15:0]       pending_r, pending_nxt_s;
   logic              overrun_r, overrun_nxt_s;
   logic              cpu_irq_r, cpu_irq_nxt_s;
   logic [3:0]        cpu_vector_r, cpu_vector_nxt_s;
   logic [DATA_W-1:0] cpu_data_r, cpu_data_nxt_s;
   logic [DATA_W-1:0] store_r [16];

   logic              event_s;
   logic              ack_s;
   logic [4:0]        winner_s;
   logic              win_valid_s;
   logic [3:0]        win_idx_s;
   logic              ovr_set_s;

   // A falling edge of the device request is one event; a held level is not.
   assign event_s     = prev_irq_r & ~srcIrq_n;
   assign winner_s    = find_winner(pending_r & mask_r);
   assign win_valid_s = winner_s[4];
   assign win_idx_s   = winner_s[3:0];

   assign cpuIrq    = cpu_irq_r;
   assign cpuVector = cpu_vector_r;
   assign cpuData   = cpu_data_r;
   assign pending   = pending_r;
   assign overrun   = overrun_r;

   // Handshake FSM next state and presented-vector registers.
   always_comb begin
      state_nxt_s      = state_r;
      cpu_irq_nxt_s    = cpu_irq_r;
      cpu_vector_nxt_s = cpu_vector_r;
      cpu_data_nxt_s   = cpu_data_r;
      ack_s            = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (win_valid_s) begin
               state_nxt_s      = ST_REQ;
               cpu_irq_nxt_s    = 1'b1;
               cpu_vector_nxt_s = win_idx_s;
               cpu_data_nxt_s   = store_r[win_idx_s];
            end else begin
               state_nxt_s      = ST_IDLE;
            end
         end
         ST_REQ: begin
            // Presented vector is frozen until the CPU accepts it.
            if (cpuAck) begin
               ack_s         = 1'b1;
               cpu_irq_nxt_s = 1'b0;
               state_nxt_s   = ST_SERVICE;
            end else begin
               state_nxt_s   = ST_REQ;
            end
         end
         ST_SERVICE: begin
            // No nesting: only EOI lets the next vector be presented.
            if (cpuEoi) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SERVICE;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            cpu_irq_nxt_s = 1'b0;
         end
      endcase
   end

   // Pending and overrun next values; a new event beats a same-cycle ack clear.
   always_comb begin
      pending_nxt_s = pending_r;
      ovr_set_s     = 1'b0;
      if (ack_s) begin
         pending_nxt_s[cpu_vector_r] = 1'b0;
      end else begin
         pending_nxt_s = pending_r;
      end
      if (event_s) begin
         pending_nxt_s[srcIndex] = 1'b1;
         ovr_set_s = pending_r[srcIndex] & ~(ack_s && (cpu_vector_r == srcIndex));
      end else begin
         ovr_set_s = 1'b0;
      end
      if (ovr_set_s) begin
         overrun_nxt_s = 1'b1;
      end else if (ovrClr) begin
         overrun_nxt_s = 1'b0;
      end else begin
         overrun_nxt_s = overrun_r;
      end
   end

   // State, edge detector, mask, pending, overrun and CPU-facing registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         prev_irq_r   <= 1'b1;
         mask_r       <= 16'hFFFF;
         pending_r    <= 16'h0000;
         overrun_r    <= 1'b0;
         cpu_irq_r    <= 1'b0;
         cpu_vector_r <= 4'd0;
         cpu_data_r   <= '0;
      end else begin
         state_r      <= state_nxt_s;
         prev_irq_r   <= srcIrq_n;
         mask_r       <= maskWe ? maskIn : mask_r;
         pending_r    <= pending_nxt_s;
         overrun_r    <= overrun_nxt_s;
         cpu_irq_r    <= cpu_irq_nxt_s;
         cpu_vector_r <= cpu_vector_nxt_s;
         cpu_data_r   <= cpu_data_nxt_s;
      end
   end

   // Per-vector data store; the latest event's data always overwrites.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            store_r[i] <= '0;
         end
      end else if (event_s) begin
         store_r[srcIndex] <= srcData;
      end else begin
         store_r <= store_r;
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with hand-computed expectations.
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        srcIrq_n;
   logic [3:0]  srcIndex;
   logic [15:0] srcData;
   logic        maskWe;
   logic [15:0] maskIn;
   logic        ovrClr;
   logic        cpuAck;
   logic        cpuEoi;
   logic        cpuIrq;
   logic [3:0]  cpuVector;
   logic [15:0] cpuData;
   logic [15:0] pending;
   logic        overrun;

   int checks_cnt = 0;
   int errors_cnt = 0;

   interrupt_controller #(.DATA_W(16)) dut (
      .clk(clk), .rst(rst), .srcIrq_n(srcIrq_n), .srcIndex(srcIndex),
      .srcData(srcData), .maskWe(maskWe), .maskIn(maskIn), .ovrClr(ovrClr),
      .cpuAck(cpuAck), .cpuEoi(cpuEoi), .cpuIrq(cpuIrq), .cpuVector(cpuVector),
      .cpuData(cpuData), .pending(pending), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_cnt++;
      if (obs !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic irq, input logic [3:0] vec,
                             input logic [15:0] dat, input logic [15:0] pend, input logic ovr);
      check_val({tag, ".irq"}, 32'(cpuIrq), 32'(irq));
      check_val({tag, ".vec"}, 32'(cpuVector), 32'(vec));
      check_val({tag, ".data"}, 32'(cpuData), 32'(dat));
      check_val({tag, ".pend"}, 32'(pending), 32'(pend));
      check_val({tag, ".ovr"}, 32'(overrun), 32'(ovr));
   endtask

   // One-cycle low pulse on srcIrq_n for index/data.
   task automatic raise(input logic [3:0] idx, input logic [15:0] dat);
      srcIndex = idx; srcData = dat; srcIrq_n = 1'b0;
      tick();
      srcIrq_n = 1'b1;
   endtask

   task automatic pulse_ack();
      cpuAck = 1'b1; tick(); cpuAck = 1'b0;
   endtask

   task automatic pulse_eoi();
      cpuEoi = 1'b1; tick(); cpuEoi = 1'b0;
   endtask

   task automatic load_mask(input logic [15:0] m);
      maskIn = m; maskWe = 1'b1; tick(); maskWe = 1'b0;
   endtask

   initial begin
      rst = 1'b0; srcIrq_n = 1'b1; srcIndex = 4'd0; srcData = 16'h0000;
      maskWe = 1'b0; maskIn = 16'hFFFF; ovrClr = 1'b0; cpuAck = 1'b0; cpuEoi = 1'b0;
      #12;
      check_outs("reset", 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0);
      rst = 1'b1;
      tick();

      // Single event, level held low for 10 cycles.
      srcIndex = 4'd1; srcData = 16'h0041; srcIrq_n = 1'b0;
      tick();
      check_outs("t1.k", 1'b0, 4'd0, 16'h0000, 16'h0002, 1'b0);
      tick();
      check_outs("t1.k1", 1'b1, 4'd1, 16'h0041, 16'h0002, 1'b0);
      for (int i = 0; i < 8; i++) tick();
      check_outs("t1.held", 1'b1, 4'd1, 16'h0041, 16'h0002, 1'b0);
      srcIrq_n = 1'b1;
      pulse_eoi();
      check_val("t1.eoi_ignored", 32'(cpuIrq), 32'd1);
      pulse_ack();
      check_outs("t1.ack", 1'b0, 4'd1, 16'h0041, 16'h0000, 1'b0);

      // Two events while servicing; lower index wins after EOI.
      raise(4'd5, 16'h0055); tick();
      raise(4'd3, 16'h0033); tick();
      check_outs("t2.busy", 1'b0, 4'd1, 16'h0041, 16'h0028, 1'b0);
      pulse_eoi();
      check_val("t2.eoi_edge", 32'(cpuIrq), 32'd0);
      tick();
      check_outs("t2.first", 1'b1, 4'd3, 16'h0033, 16'h0028, 1'b0);
      pulse_ack(); pulse_eoi(); tick();
      check_outs("t2.second", 1'b1, 4'd5, 16'h0055, 16'h0020, 1'b0);
      pulse_ack(); pulse_eoi();
      check_val("t2.drained", 32'(pending), 32'h0);

      // Masked vector accumulates but is not presented until unmasked.
      load_mask(16'hFFFD);
      raise(4'd1, 16'h0101);
      check_val("t3.pend", 32'(pending), 32'h0002);
      tick(); tick();
      check_val("t3.masked_irq", 32'(cpuIrq), 32'd0);
      pulse_ack();
      check_val("t3.ack_idle_ignored", 32'(pending), 32'h0002);
      load_mask(16'hFFFF);
      check_val("t3.unmask_edge", 32'(cpuIrq), 32'd0);
      tick();
      check_outs("t3.present", 1'b1, 4'd1, 16'h0101, 16'h0002, 1'b0);
      pulse_ack(); pulse_eoi();

      // Overrun: second event on an unacknowledged vector, latest data wins.
      load_mask(16'hFFFB);
      raise(4'd2, 16'h1111); tick();
      raise(4'd2, 16'h2222);
      check_val("t4.ovr", 32'(overrun), 32'd1);
      check_val("t4.pend", 32'(pending), 32'h0004);
      load_mask(16'hFFFF);
      tick();
      check_outs("t4.present", 1'b1, 4'd2, 16'h2222, 16'h0004, 1'b1);
      ovrClr = 1'b1; tick(); ovrClr = 1'b0;
      check_val("t4.ovrclr", 32'(overrun), 32'd0);
      pulse_ack(); pulse_eoi();

      // Ack and a new event for the same vector on one edge: set wins.
      raise(4'd6, 16'h0666);
      tick();
      check_outs("t5.present", 1'b1, 4'd6, 16'h0666, 16'h0040, 1'b0);
      srcIndex = 4'd6; srcData = 16'h0777; srcIrq_n = 1'b0; cpuAck = 1'b1;
      tick();
      srcIrq_n = 1'b1; cpuAck = 1'b0;
      check_outs("t5.collide", 1'b0, 4'd6, 16'h0666, 16'h0040, 1'b0);
      pulse_eoi(); tick();
      check_outs("t5.represent", 1'b1, 4'd6, 16'h0777, 16'h0040, 1'b0);
      pulse_ack(); pulse_eoi();

      // Reset pulse while a vector is presented, then a fresh event.
      raise(4'd7, 16'h0077); tick();
      check_val("t6.inreq", 32'(cpuIrq), 32'd1);
      rst = 1'b0; #1;
      check_outs("t6.rst", 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0);
      #2 rst = 1'b1;
      tick();
      srcIndex = 4'd4; srcData = 16'h0044; srcIrq_n = 1'b0;
      tick();
      srcIrq_n = 1'b1;
      check_outs("t6.k", 1'b0, 4'd0, 16'h0000, 16'h0010, 1'b0);
      tick();
      check_outs("t6.k1", 1'b1, 4'd4, 16'h0044, 16'h0010, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
